// File: rtl/cnn_quad_conv_engine_if.sv
// rtl/cnn_quad_conv_engine_if.sv - job, fetch stream and result stream bundle for the quad conv engine
interface cnn_quad_conv_engine_if;
    logic         job_start;
    logic         job_accept;
    logic [127:0] job_parameters;
    logic         job_fetch_request;
    logic         job_fetch_ack;
    logic         job_fetch_complete;
    logic         job_complete;
    logic         job_complete_ack;
    logic [3:0]   config_valid;
    logic [3:0]   config_accept;
    logic [127:0] config_data;
    logic         weight_valid;
    logic         weight_ready;
    logic [127:0] weight_data;
    logic         pixel_valid;
    logic         pixel_ready;
    logic [127:0] pixel_data;
    logic         result_valid;
    logic         result_accept;
    logic [15:0]  result_data;

    modport master (
        output job_start, job_parameters, job_fetch_ack, job_complete_ack,
               config_valid, config_data, weight_valid, weight_data,
               pixel_valid, pixel_data, result_accept,
        input  job_accept, job_fetch_request, job_fetch_complete, job_complete,
               config_accept, weight_ready, pixel_ready, result_valid, result_data
    );

    modport slave (
        input  job_start, job_parameters, job_fetch_ack, job_complete_ack,
               config_valid, config_data, weight_valid, weight_data,
               pixel_valid, pixel_data, result_accept,
        output job_accept, job_fetch_request, job_fetch_complete, job_complete,
               config_accept, weight_ready, pixel_ready, result_valid, result_data
    );
endinterface

// File: rtl/cnn_quad_conv_engine.sv
// rtl/cnn_quad_conv_engine.sv - 4-lane 3x3 strided, zero-padded convolution engine
// Loads kernels then image into local RAM, then evaluates one tap (all lanes) per cycle.
module cnn_quad_conv_engine #(
    parameter int NUM_CE      = 4,
    parameter int MAX_DIM     = 20,
    parameter int MAX_KERNELS = 16
) (
    input  logic                    clk_core,
    input  logic                    rst,
    cnn_quad_conv_engine_if.slave   bus
);
    localparam int IMG_DEPTH = MAX_DIM * MAX_DIM;
    localparam int W_DEPTH   = MAX_KERNELS * 9;
    localparam int IMG_AW    = $clog2(IMG_DEPTH);
    localparam int W_AW      = $clog2(W_DEPTH);
    localparam int LANE_W    = 16 * NUM_CE;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WLOAD, S_PLOAD, S_COMP, S_FLUSH, S_DONE} state_t;

    state_t state_q, state_d;

    logic [15:0] rows_q, cols_q;
    logic [7:0]  nk_q;
    logic        stride2_q, pad_q;
    logic [11:0] wcnt_q;
    logic [31:0] pcnt_q;
    logic [16:0] out_r_q, out_c_q;
    logic [7:0]  k_q;
    logic [1:0]  ky_q, kx_q;
    logic signed [39:0] acc_q;
    logic        result_valid_q;
    logic [15:0] result_data_q;
    logic        job_accept_q, fetch_done_q;
    logic [3:0]  config_accept_q;

    logic [LANE_W-1:0] img_mem [IMG_DEPTH];
    logic [LANE_W-1:0] w_mem   [W_DEPTH];

    logic [11:0] w_total;
    logic [31:0] npix;
    logic [16:0] span_r, span_c, out_rows, out_cols;
    logic        w_fire, p_fire;

    assign w_total = {4'b0, nk_q} * 12'd9;
    assign npix    = 32'(rows_q) * 32'(cols_q);
    assign span_r  = {1'b0, rows_q} + {15'b0, pad_q, 1'b0};
    assign span_c  = {1'b0, cols_q} + {15'b0, pad_q, 1'b0};
    // Images smaller than the kernel window (after padding) yield no outputs.
    assign out_rows = (span_r < 17'd3) ? 17'd0 : ((span_r - 17'd3) >> stride2_q) + 17'd1;
    assign out_cols = (span_c < 17'd3) ? 17'd0 : ((span_c - 17'd3) >> stride2_q) + 17'd1;

    assign w_fire = (state_q == S_WLOAD) && (wcnt_q != w_total) && bus.weight_valid;
    assign p_fire = (state_q == S_PLOAD) && (pcnt_q != npix) && bus.pixel_valid;

    // Tap datapath: map the current output position and tap to an input pixel.
    logic [19:0] iy, ix;
    logic        in_bounds;
    logic [31:0] pix_addr;
    logic [11:0] w_addr;
    logic [LANE_W-1:0] pix_word, w_word;
    logic signed [39:0] tap_sum, acc_next;
    logic [15:0] sat_val;

    always_comb begin
        iy = (stride2_q ? {2'b0, out_r_q, 1'b0} : {3'b0, out_r_q}) - {19'b0, pad_q} + {18'b0, ky_q};
        ix = (stride2_q ? {2'b0, out_c_q, 1'b0} : {3'b0, out_c_q}) - {19'b0, pad_q} + {18'b0, kx_q};
        in_bounds = !iy[19] && !ix[19] && (iy < {4'b0, rows_q}) && (ix < {4'b0, cols_q});
        pix_addr  = 32'(iy[15:0]) * 32'(cols_q) + 32'(ix[15:0]);
        w_addr    = {4'b0, k_q} * 12'd9 + {10'b0, ky_q} * 12'd3 + {10'b0, kx_q};
        pix_word  = (in_bounds && pix_addr < 32'(IMG_DEPTH)) ? img_mem[pix_addr[IMG_AW-1:0]] : '0;
        w_word    = (w_addr < 12'(W_DEPTH)) ? w_mem[w_addr[W_AW-1:0]] : '0;
        tap_sum   = '0;
        for (int c = 0; c < NUM_CE; c++) begin
            tap_sum = tap_sum + 40'($signed(pix_word[16*c +: 16]) * $signed(w_word[16*c +: 16]));
        end
        acc_next = acc_q + tap_sum;
        if (acc_next > 40'sd32767)
            sat_val = 16'h7FFF;
        else if (acc_next < -40'sd32768)
            sat_val = 16'h8000;
        else
            sat_val = acc_next[15:0];
    end

    logic comp_empty, last_tap, last_k, last_c, last_r, emit_ok, comp_adv;

    assign comp_empty = (out_rows == 17'd0) || (out_cols == 17'd0);
    assign last_tap   = (ky_q == 2'd2) && (kx_q == 2'd2);
    assign last_k     = (k_q == nk_q - 8'd1);
    assign last_c     = (out_c_q == out_cols - 17'd1);
    assign last_r     = (out_r_q == out_rows - 17'd1);
    // A finished sum may only be written once the previous result has left.
    assign emit_ok    = !result_valid_q || bus.result_accept;
    assign comp_adv   = (state_q == S_COMP) && !comp_empty && (!last_tap || emit_ok);

    always_comb begin
        state_d               = state_q;
        bus.job_fetch_request = 1'b0;
        bus.weight_ready      = 1'b0;
        bus.pixel_ready       = 1'b0;
        bus.job_complete      = 1'b0;
        unique case (state_q)
            S_IDLE:  if (bus.job_start) state_d = S_REQ;
            S_REQ: begin
                bus.job_fetch_request = 1'b1;
                if (bus.job_fetch_ack) state_d = S_WLOAD;
            end
            S_WLOAD: begin
                bus.weight_ready = (wcnt_q != w_total);
                if (wcnt_q == w_total) state_d = S_PLOAD;
            end
            S_PLOAD: begin
                bus.pixel_ready = (pcnt_q != npix);
                if (pcnt_q == npix) state_d = S_COMP;
            end
            S_COMP: begin
                if (comp_empty)
                    state_d = S_DONE;
                else if (comp_adv && last_tap && last_k && last_c && last_r)
                    state_d = S_FLUSH;
            end
            S_FLUSH: if (!result_valid_q || bus.result_accept) state_d = S_DONE;
            S_DONE: begin
                bus.job_complete = 1'b1;
                if (bus.job_complete_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.job_accept         = job_accept_q;
    assign bus.job_fetch_complete = fetch_done_q;
    assign bus.config_accept      = config_accept_q;
    assign bus.result_valid       = result_valid_q;
    assign bus.result_data        = result_data_q;

    always_ff @(posedge clk_core) begin
        if (rst) begin
            state_q         <= S_IDLE;
            rows_q          <= '0;
            cols_q          <= '0;
            nk_q            <= 8'd1;
            stride2_q       <= 1'b0;
            pad_q           <= 1'b0;
            wcnt_q          <= '0;
            pcnt_q          <= '0;
            out_r_q         <= '0;
            out_c_q         <= '0;
            k_q             <= '0;
            ky_q            <= '0;
            kx_q            <= '0;
            acc_q           <= '0;
            result_valid_q  <= 1'b0;
            result_data_q   <= '0;
            job_accept_q    <= 1'b0;
            fetch_done_q    <= 1'b0;
            config_accept_q <= '0;
        end else begin
            state_q         <= state_d;
            config_accept_q <= bus.config_valid;
            job_accept_q    <= (state_q == S_IDLE) && bus.job_start;
            fetch_done_q    <= (state_q == S_PLOAD) && (pcnt_q == npix);
            if (result_valid_q && bus.result_accept) result_valid_q <= 1'b0;
            if (w_fire) wcnt_q <= wcnt_q + 12'd1;
            if (p_fire) pcnt_q <= pcnt_q + 32'd1;

            if (state_q == S_IDLE) begin
                wcnt_q  <= '0;
                pcnt_q  <= '0;
                out_r_q <= '0;
                out_c_q <= '0;
                k_q     <= '0;
                ky_q    <= '0;
                kx_q    <= '0;
                acc_q   <= '0;
                if (bus.job_start) begin
                    rows_q    <= bus.job_parameters[15:0];
                    cols_q    <= bus.job_parameters[31:16];
                    nk_q      <= (bus.job_parameters[39:32] == 8'd0) ? 8'd1 : bus.job_parameters[39:32];
                    stride2_q <= (bus.job_parameters[43:40] >= 4'd2);
                    pad_q     <= (bus.job_parameters[47:44] != 4'd0);
                end
            end

            if (comp_adv) begin
                if (last_tap) begin
                    result_data_q  <= sat_val;
                    result_valid_q <= 1'b1;
                    acc_q          <= '0;
                    ky_q           <= '0;
                    kx_q           <= '0;
                    // Kernel index runs innermost, then column, then row.
                    if (last_k) begin
                        k_q <= '0;
                        if (last_c) begin
                            out_c_q <= '0;
                            out_r_q <= out_r_q + 17'd1;
                        end else begin
                            out_c_q <= out_c_q + 17'd1;
                        end
                    end else begin
                        k_q <= k_q + 8'd1;
                    end
                end else begin
                    acc_q <= acc_next;
                    if (kx_q == 2'd2) begin
                        kx_q <= '0;
                        ky_q <= ky_q + 2'd1;
                    end else begin
                        kx_q <= kx_q + 2'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (w_fire && wcnt_q < 12'(W_DEPTH)) w_mem[wcnt_q[W_AW-1:0]] <= bus.weight_data[LANE_W-1:0];
        if (p_fire && pcnt_q < 32'(IMG_DEPTH)) img_mem[pcnt_q[IMG_AW-1:0]] <= bus.pixel_data[LANE_W-1:0];
    end

    logic unused_bits;
    assign unused_bits = ^{bus.config_data, bus.job_parameters[127:48],
                           bus.weight_data[127:LANE_W], bus.pixel_data[127:LANE_W]};
endmodule

// File: tb/tb_cnn_quad_conv_engine.sv
// tb/tb_cnn_quad_conv_engine.sv - directed scoreboard bench for cnn_quad_conv_engine
module tb_cnn_quad_conv_engine;
    logic clk_core = 1'b0;
    logic rst;
    always #5 clk_core = ~clk_core;

    cnn_quad_conv_engine_if bus();
    cnn_quad_conv_engine dut (.clk_core(clk_core), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [15:0] img [0:399][0:3];
    logic [15:0] wts [0:143][0:3];
    logic [15:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    task automatic fill_const(input logic [15:0] pv, input logic [15:0] wv);
        for (int i = 0; i < 400; i++) for (int c = 0; c < 4; c++) img[i][c] = pv;
        for (int i = 0; i < 144; i++) for (int c = 0; c < 4; c++) wts[i][c] = wv;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_accept"}, 32'(bus.job_accept), 0);
        chk({tag, "_freq"}, 32'(bus.job_fetch_request), 0);
        chk({tag, "_fdone"}, 32'(bus.job_fetch_complete), 0);
        chk({tag, "_jdone"}, 32'(bus.job_complete), 0);
        chk({tag, "_cfg"}, 32'(bus.config_accept), 0);
        chk({tag, "_wrdy"}, 32'(bus.weight_ready), 0);
        chk({tag, "_prdy"}, 32'(bus.pixel_ready), 0);
        chk({tag, "_rvalid"}, 32'(bus.result_valid), 0);
        chk({tag, "_rdata"}, 32'(bus.result_data), 0);
    endtask

    task automatic build_exp(input int rows, input int cols, input int nk, input int s, input int p);
        int orr, occ;
        longint sum;
        orr = (rows + 2*p - 3) / s + 1;
        occ = (cols + 2*p - 3) / s + 1;
        for (int r = 0; r < orr; r++)
            for (int c = 0; c < occ; c++)
                for (int k = 0; k < nk; k++) begin
                    sum = 0;
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++) begin
                            int iy, ix;
                            iy = r*s - p + ky;
                            ix = c*s - p + kx;
                            if (iy >= 0 && iy < rows && ix >= 0 && ix < cols)
                                for (int ch = 0; ch < 4; ch++)
                                    sum += longint'($signed(img[iy*cols+ix][ch])) *
                                           longint'($signed(wts[k*9+ky*3+kx][ch]));
                        end
                    if (sum > 32767) exp_q.push_back(16'h7FFF);
                    else if (sum < -32768) exp_q.push_back(16'h8000);
                    else exp_q.push_back(16'(sum));
                end
    endtask

    task automatic start_and_load(input int rows, input int cols, input int nk_raw, input int s_raw,
                                  input int p_raw, input int pix_limit, input string tag);
        int nk, seen, bound;
        nk = (nk_raw == 0) ? 1 : nk_raw;
        bus.job_parameters = {80'h0, 4'(p_raw), 4'(s_raw), 8'(nk_raw), 16'(cols), 16'(rows)};
        bus.job_start = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            step();
            if (bus.job_accept) seen = 1;
        end
        bus.job_start = 1'b0;
        chk({tag, "_job_accept"}, 32'(seen), 1);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            if (bus.job_fetch_request) seen = 1;
            else step();
        end
        chk({tag, "_fetch_req"}, 32'(seen), 1);
        bus.job_fetch_ack = 1'b1;
        step();
        bus.job_fetch_ack = 1'b0;
        for (int i = 0; i < nk*9; i++) begin
            bus.weight_valid = 1'b1;
            bus.weight_data = {64'hDEAD_BEEF_CAFE_F00D, wts[i][3], wts[i][2], wts[i][1], wts[i][0]};
            bound = 0;
            while (!bus.weight_ready && bound < 50) begin step(); bound++; end
            if (bound >= 50) begin chk({tag, "_wready_timeout"}, 32'(bound), 0); break; end
            step();
        end
        bus.weight_valid = 1'b0;
        for (int i = 0; i < pix_limit; i++) begin
            bus.pixel_valid = 1'b1;
            bus.pixel_data = {64'h5A5A_A5A5_0F0F_F0F0, img[i][3], img[i][2], img[i][1], img[i][0]};
            bound = 0;
            while (!bus.pixel_ready && bound < 50) begin step(); bound++; end
            if (bound >= 50) begin chk({tag, "_pready_timeout"}, 32'(bound), 0); break; end
            step();
        end
        bus.pixel_valid = 1'b0;
    endtask

    task automatic run_job(input int rows, input int cols, input int nk_raw, input int s_raw,
                           input int p_raw, input int acc_pct, input string tag);
        int nk, s, p, n, got, extra, seen, budget;
        nk = (nk_raw == 0) ? 1 : nk_raw;
        s  = (s_raw == 0) ? 1 : ((s_raw > 2) ? 2 : s_raw);
        p  = (p_raw > 0) ? 1 : 0;
        build_exp(rows, cols, nk, s, p);
        n = exp_q.size();
        start_and_load(rows, cols, nk_raw, s_raw, p_raw, rows*cols, tag);
        seen = 0;
        for (int i = 0; i < 6 && seen == 0; i++) begin
            if (bus.job_fetch_complete) seen = 1;
            else step();
        end
        chk({tag, "_fetch_complete"}, 32'(seen), 1);
        got = 0;
        budget = n*40 + 200;
        while (got < n && budget > 0) begin
            bus.result_accept = ($urandom_range(99) < acc_pct);
            if (bus.result_valid && bus.result_accept) begin
                chk($sformatf("%s_res%0d", tag, got), 32'(bus.result_data), 32'(exp_q.pop_front()));
                got++;
            end
            step();
            budget--;
        end
        bus.result_accept = 1'b0;
        chk({tag, "_result_count"}, 32'(got), 32'(n));
        exp_q.delete();
        seen = 0;
        extra = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            if (bus.result_valid) extra++;
            if (bus.job_complete) seen = 1;
            else step();
        end
        chk({tag, "_job_complete"}, 32'(seen), 1);
        chk({tag, "_extra_results"}, 32'(extra), 0);
        bus.job_complete_ack = 1'b1;
        step();
        bus.job_complete_ack = 1'b0;
        step();
        chk({tag, "_complete_cleared"}, 32'(bus.job_complete), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.job_start = 1'b0;
        bus.job_parameters = '0;
        bus.job_fetch_ack = 1'b0;
        bus.job_complete_ack = 1'b0;
        bus.config_valid = 4'b0;
        bus.config_data = '0;
        bus.weight_valid = 1'b0;
        bus.weight_data = '0;
        bus.pixel_valid = 1'b0;
        bus.pixel_data = '0;
        bus.result_accept = 1'b0;
        repeat (3) step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();

        bus.config_valid = 4'b1010;
        step();
        chk("config_accept", 32'(bus.config_accept), 32'h0000_000A);
        bus.config_valid = 4'b0;
        step();
        chk("config_accept_clear", 32'(bus.config_accept), 0);

        fill_const(16'd1, 16'd1);
        run_job(5, 5, 1, 1, 0, 100, "ones_s1p0");
        run_job(5, 5, 1, 1, 1, 60, "ones_s1p1");
        run_job(5, 5, 1, 2, 0, 100, "ones_s2p0");
        run_job(5, 5, 0, 0, 5, 80, "ones_sanitised");

        fill_const(16'h7FFF, 16'h7FFF);
        run_job(5, 5, 1, 1, 0, 100, "sat_pos");
        fill_const(16'h8000, 16'h7FFF);
        run_job(5, 5, 1, 1, 0, 100, "sat_neg");

        for (int i = 0; i < 400; i++) for (int c = 0; c < 4; c++) img[i][c] = 16'((i + 3*c) & 8'hFF);
        for (int i = 0; i < 144; i++) for (int c = 0; c < 4; c++) wts[i][c] = 16'(((i + 5*c) % 7) - 3);
        run_job(20, 20, 11, 1, 0, 70, "ramp_s1p0");
        run_job(20, 20, 11, 2, 1, 50, "ramp_s2p1");

        fill_const(16'd1, 16'd1);
        start_and_load(5, 5, 1, 1, 0, 10, "abort");
        rst = 1'b1;
        step();
        step();
        check_idle_outputs("abort_reset");
        rst = 1'b0;
        step();
        run_job(5, 5, 1, 1, 0, 100, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
